// File: rtl/multicycle_control_fsm.sv
// Multicycle RISC-V control sequencer.
// Steps lw, sw, R-type, I-type ALU and beq through fetch, decode, execute and
// writeback. It drives the ALU operation code, the ALU source selects and the
// datapath write enables.
//
// state | meaning
// ------+------------------------------------------------------------
// 0     | FETCH    : read the instruction, load IR, PC <= PC + 4
// 1     | DECODE   : ALUOut <= OldPC + imm (branch target), dispatch
// 2     | MEMADR   : ALU computes rs1 + imm for lw/sw
// 3     | MEMREAD  : read data memory at ALUOut
// 4     | MEMWB    : write loaded data to the register file
// 5     | MEMWRITE : write rs2 data to memory at ALUOut
// 6     | EXECR    : ALU computes rs1 op rs2
// 7     | EXECI    : ALU computes rs1 op imm
// 8     | ALUWB    : write ALUOut to the register file
// 9     | BEQ      : compare rs1 and rs2, PC <= ALUOut if they are equal
// 10-15 | unused   : return to FETCH with all enables low
module multicycle_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       ir_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] ALU_control,
    output logic [3:0] state
);

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOP = 4'b1111;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9
    } state_t;

    state_t state_q;
    state_t state_d;

    logic pc_write_d;
    logic ir_write_d;
    logic mem_write_d;
    logic reg_write_d;

    // funct3 to ALU code; sub_sel is funct7b5 for R-type and tied low for I-type
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic sub_sel);
        logic [3:0] code;
        case (f3)
            3'b000:  code = sub_sel ? ALU_SUB : ALU_ADD;
            3'b010:  code = ALU_SLT;
            3'b110:  code = ALU_OR;
            3'b111:  code = ALU_AND;
            default: code = ALU_NOP;
        endcase
        return code;
    endfunction

    // State register; reset lands in FETCH immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore output decode
    always_comb begin
        state_d     = S_FETCH;
        pc_write_d  = 1'b0;
        ir_write_d  = 1'b0;
        mem_write_d = 1'b0;
        reg_write_d = 1'b0;
        adr_src     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        ALU_control = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                ir_write_d = 1'b1;
                pc_write_d = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BEQ:            state_d = S_BEQ;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                reg_write_d = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                mem_write_d = 1'b1;
                state_d     = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a   = 2'b10;
                ALU_control = alu_decode(funct3, funct7b5);
                state_d     = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                ALU_control = alu_decode(funct3, 1'b0);
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_d = 1'b1;
                state_d     = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a   = 2'b10;
                ALU_control = ALU_SUB;
                pc_write_d  = zero;
                state_d     = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Enables are held low for as long as reset is asserted
    always_comb begin
        pc_write  = pc_write_d & ~reset;
        ir_write  = ir_write_d & ~reset;
        mem_write = mem_write_d & ~reset;
        reg_write = reg_write_d & ~reset;
    end

    assign state = state_q;

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multicycle RISC-V control sequencer. It is the producer side of the ALU interface: it generates ALU_control (ALU encoding below), the srcA/srcB mux selects, and the datapath write enables, stepping each instruction through fetch/decode/execute/writeback states.
- Supported instructions: lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq.
- Sits between the instruction register and the shared multicycle datapath.

Parameters:
- ALU_ADD, 4'b0010, add code.
- ALU_SUB, 4'b0110, subtract code.
- ALU_AND, 4'b0000, AND code.
- ALU_OR, 4'b0001, OR code.
- ALU_SLT, 4'b0111, set-less-than code.
- ALU_NOP, 4'b1111, unsupported op; ALU returns 0.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- opcode  in  7  instr[6:0] from the instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU_result == 0 flag from the datapath
- pc_write  out  1  PC register load
- ir_write  out  1  instruction register load
- adr_src  out  1  memory address: 0 = PC, 1 = result
- mem_write  out  1  data memory write
- reg_write  out  1  register file write
- result_src  out  2  00 = ALUOut register, 01 = memory data, 10 = ALU_result
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rs1 data
- alu_src_b  out  2  00 = rs2 data, 01 = immediate, 10 = constant 4
- ALU_control  out  4  ALU operation code
- state  out  4  current state, for debug and verification

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-high on reset, and forces state = FETCH (0) immediately.
- Outputs are a Moore decode of the state register, plus opcode/funct for the ALU code and zero for branches. There is no extra output latency.
- While reset = 1, pc_write, ir_write, mem_write and reg_write are forced to 0. All other outputs take their FETCH values.
- Any output not listed for a state is 0. ALU_control is ALU_ADD unless stated otherwise.
- FETCH (0): adr_src=0, ir_write=1, a=00, b=10, ADD, result_src=10, pc_write=1. Next state: DECODE.
- DECODE (1): a=01, b=01, ADD (branch target captured in ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - anything else -> FETCH, with no writes.
- MEMADR (2): a=10, b=01, ADD. Next state: MEMREAD if opcode = 0000011, otherwise MEMWRITE.
- MEMREAD (3): adr_src=1, result_src=00. Next state: MEMWB.
- MEMWB (4): result_src=01, reg_write=1. Next state: FETCH.
- MEMWRITE (5): adr_src=1, result_src=00, mem_write=1. Next state: FETCH.
- EXECR (6): a=10, b=00, ALU code from the R-type decode. Next state: ALUWB.
- EXECI (7): a=10, b=01, ALU code from the I-type decode. Next state: ALUWB.
- ALUWB (8): result_src=00, reg_write=1. Next state: FETCH.
- BEQ (9): a=10, b=00, SUB, result_src=00, pc_write=zero. Next state: FETCH.
- ALU decode, R-type:
  - funct3 000 with funct7b5=1 -> SUB; funct3 000 with funct7b5=0 -> ADD
  - 010 -> SLT; 110 -> OR; 111 -> AND
  - all other funct3 -> ALU_NOP
- ALU decode, I-type: identical, except funct7b5 is ignored, so 000 always gives ADD.
- State encodings 10-15 are unreachable. If entered, next state = FETCH and all enables = 0.
- Cycle counts: lw 5, sw 4, R-type and I-type 4, beq 3, illegal opcode 2.
- Inputs are sampled each cycle. The instruction register holds them stable from DECODE until the instruction completes.

Test Plan:
- Reset: assert reset mid-MEMREAD -> state=0 immediately and all enables 0. Deassert -> FETCH outputs: ir_write=1, pc_write=1, a=00, b=10, ALU_control=0010.
- lw (opcode 0000011) -> states 0,1,2,3,4,0. reg_write=1 only in state 4, with result_src=01. MEMADR has ALU_control=0010, b=01.
- sw (opcode 0100011) -> states 0,1,2,5,0. mem_write=1 only in state 5, with adr_src=1.
- R-type (opcode 0110011): funct3=000/funct7b5=1 -> ALU_control=0110 in EXECR. funct3=010 -> 0111. funct3=111 -> 0000. funct3=001 -> 1111. ALUWB then has reg_write=1.
- addi (opcode 0010011, funct3=000, funct7b5=1) -> ALU_control=0010 in EXECI, b=01.
- beq (opcode 1100011): with zero=1 -> pc_write=1 in state 9. With zero=0 -> pc_write=0. ALU_control=0110 in both cases.
- Illegal opcode 1111111 -> states 0,1,0 with no reg_write and no mem_write.
